// File: rtl/rr_grant_ctrl_pkg.sv
// rr_arb_pkg: shared types and index helpers for the round-robin arbiter.
package rr_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
   function automatic int idx_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
   // Sum carries one spare bit so a single conditional subtract reduces it.
   function automatic int mod_add(input int a, input int b, input int w);
      int s;
      s = a + b;
      return (s >= w) ? s - w : s;
   endfunction
endpackage

// File: rtl/rr_grant_ctrl_if.sv
// rr_grant_ctrl_if: request/ring/grant signals between the arbiter control and its environment.
interface rr_grant_ctrl_if import rr_arb_pkg::*; #(parameter int W_DATA = 5);
   localparam int IW = idx_w(W_DATA);
   logic [W_DATA-1:0] req_in;
   logic [W_DATA-1:0] rot_req_in;
   logic rot_req_valid;
   logic release_in;
   logic [IW-1:0] ptr_out;
   logic [W_DATA-1:0] grant_out;
   logic [IW-1:0] grant_idx;
   logic grant_valid;
   modport master (output req_in, rot_req_in, rot_req_valid, release_in,
                   input ptr_out, grant_out, grant_idx, grant_valid);
   modport slave (input req_in, rot_req_in, rot_req_valid, release_in,
                  output ptr_out, grant_out, grant_idx, grant_valid);
endinterface

// File: rtl/rr_grant_ctrl_lsb_pick.sv
// rr_lsb_pick: position of the lowest set bit of a vector, with a found flag.
module rr_lsb_pick import rr_arb_pkg::*; #(
   parameter int W_DATA = 5
) (
   input logic [W_DATA-1:0] vec,
   output logic [idx_w(W_DATA)-1:0] pos,
   output logic found
);
   localparam int IW = idx_w(W_DATA);
   always_comb begin
      pos = '0;
      for (int i = W_DATA - 1; i >= 0; i--) if (vec[i]) pos = IW'(i);
   end
   assign found = |vec;
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant FSM; drives the ring pointer and holds a one-hot grant.
module rr_grant_ctrl import rr_arb_pkg::*; #(
   parameter int W_DATA = 5,
   parameter int MAX_HOLD = 8
) (
   input logic clk,
   input logic rst_n,
   rr_grant_ctrl_if.slave bus
);
   localparam int IW = idx_w(W_DATA);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_GRANT = 2'(GRANT);
   localparam logic [1:0] S_RELEASE = 2'(RELEASE);
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] ptr, gidx, pos, idx, nxt;
   logic [W_DATA-1:0] grant;
   logic gvalid, found, go, done;
   rr_lsb_pick #(.W_DATA(W_DATA)) u_pick (.vec(bus.rot_req_in), .pos(pos), .found(found));
   assign idx = IW'(mod_add(int'(ptr), int'(pos), W_DATA));
   assign nxt = IW'(mod_add(int'(idx), 1, W_DATA));
   assign go = (state == S_IDLE) && bus.rot_req_valid && found;
   assign done = bus.release_in || !bus.req_in[gidx] || (cnt == CW'(MAX_HOLD));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_IDLE;
         cnt <= '0;
         ptr <= '0;
         gidx <= '0;
         grant <= '0;
         gvalid <= 1'b0;
      end else if (go) begin
         state <= S_GRANT;
         grant <= W_DATA'(1) << idx;
         gidx <= idx;
         gvalid <= 1'b1;
         ptr <= nxt;
         cnt <= CW'(1);
      end else if (state == S_GRANT && done) begin
         state <= S_RELEASE;
         grant <= '0;
         gvalid <= 1'b0;
         cnt <= '0;
      end else if (state == S_GRANT) begin
         cnt <= (cnt == CW'(MAX_HOLD)) ? cnt : cnt + CW'(1);
      end else if (state == S_RELEASE) begin
         state <= S_IDLE;
      end
   assign bus.ptr_out = ptr;
   assign bus.grant_out = grant;
   assign bus.grant_idx = gidx;
   assign bus.grant_valid = gvalid;
   a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
   a_rot_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.rot_req_valid && bus.rot_req_in == '0));
endmodule
